stego_seq_ctrl: RTL and testbench

STEGO_SEQ_CTRL -- requirements
Module: stego_seq_ctrl

---
 rtl/stego_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_stego_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stego_seq_ctrl.sv
// stego_seq_ctrl: Wishbone-controlled LSB steganography embed/extract engine for 32-pixel frames
module stego_seq_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pix_in_valid,
    input  logic [7:0]  pix_in_data,
    output logic        pix_in_ready,
    output logic        pix_out_valid,
    output logic [7:0]  pix_out_data,
    input  logic        pix_out_ready,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t      state_q, state_d;
    logic        ack_q, mode_q, irq_en_q, run_mode_q, done_q, ovr_q, ov_q;
    logic [31:0] dat_q, key_q, data_q, s_q, rdata;
    logic [4:0]  c_q;
    logic [7:0]  od_q;
    logic [2:0]  off;
    logic        req, wr, busy, start, accept, finish, w1c_done, w1c_ovr, unused;

    assign req      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
    assign wr       = req & wbs_we_i;
    assign off      = wbs_adr_i[4:2];
    assign busy     = state_q != IDLE;
    assign start    = wr & (off == 3'd0) & wbs_sel_i[0] & wbs_dat_i[0];
    assign w1c_done = wr & (off == 3'd1) & wbs_sel_i[0] & wbs_dat_i[1];
    assign w1c_ovr  = wr & (off == 3'd1) & wbs_sel_i[0] & wbs_dat_i[2];
    assign accept   = pix_in_valid & pix_in_ready;
    assign finish   = (state_q == DRAIN) & (~ov_q | pix_out_ready);
    assign unused   = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    assign pix_in_ready  = (state_q == RUN) & (~ov_q | pix_out_ready);
    assign pix_out_valid = ov_q;
    assign pix_out_data  = od_q;
    assign irq           = done_q & irq_en_q;
    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = dat_q;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // register read mux; START always reads back as 0
    always_comb begin
        rdata = (off == 3'd0) ? {29'b0, irq_en_q, mode_q, 1'b0} :
                (off == 3'd1) ? {29'b0, ovr_q, done_q, busy} :
                (off == 3'd2) ? key_q :
                (off == 3'd3) ? data_q : 32'b0;
    end

    // frame sequencing: start, last pixel accepted, output register drained
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && start) state_d = RUN;
        if (state_q == RUN && accept && c_q == 5'd31) state_d = DRAIN;
        if (finish) state_d = IDLE;
    end

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // single-cycle ack with registered read data
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= 32'b0;
        end else begin
            ack_q <= req;
            if (req) dat_q <= rdata;
        end
    end

    // software-visible registers; DONE set beats its own clear
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            key_q    <= 32'b0;
            data_q   <= 32'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr && off == 3'd0 && wbs_sel_i[0]) begin
                mode_q   <= wbs_dat_i[1];
                irq_en_q <= wbs_dat_i[2];
            end
            if (wr && off == 3'd2 && !busy) key_q <= merge(key_q, wbs_dat_i, wbs_sel_i);
            if (wr && off == 3'd3 && !busy) data_q <= merge(data_q, wbs_dat_i, wbs_sel_i);
            if (finish && run_mode_q) data_q <= s_q ^ key_q;
            done_q <= finish | (done_q & ~w1c_done);
            ovr_q  <= (start & busy) | (ovr_q & ~w1c_ovr);
        end
    end

    // pixel datapath: shift-register bit select, one-deep output register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s_q        <= 32'b0;
            c_q        <= 5'd0;
            ov_q       <= 1'b0;
            od_q       <= 8'b0;
            run_mode_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                s_q        <= wbs_dat_i[1] ? 32'b0 : data_q ^ key_q;
                c_q        <= 5'd0;
                run_mode_q <= wbs_dat_i[1];
            end
            if (accept) begin
                od_q <= run_mode_q ? pix_in_data : {pix_in_data[7:1], s_q[c_q]};
                if (run_mode_q) s_q[c_q] <= pix_in_data[0];
                ov_q <= 1'b1;
                c_q  <= c_q + 5'd1;
            end else if (ov_q && pix_out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stego_seq_ctrl.sv
// tb_stego_seq_ctrl: directed + randomized frames against a bit-level reference model
module tb_stego_seq_ctrl;
    localparam logic [31:0] B = 32'h3000_0000;
    localparam logic [31:0] CTRL = B + 32'h00, STATUS = B + 32'h04, KEY = B + 32'h08, DATA = B + 32'h0C;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, dat_i = 32'h0, dat_o;
    logic        ack, piv = 1'b0, pir, pov, por = 1'b1, irq;
    logic [7:0]  pid = 8'h0, pod;

    int checks = 0, errors = 0;
    int stab_err = 0, rdy_err = 0, stall_seen = 0;
    logic       hold_q = 1'b0;
    logic [7:0] hold_d = 8'h0;
    logic [7:0] outq[$];
    logic [7:0] pix[32];

    always #5 clk = ~clk;

    stego_seq_ctrl #(.BASE_ADDR(B)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .pix_in_valid(piv), .pix_in_data(pid), .pix_in_ready(pir),
        .pix_out_valid(pov), .pix_out_data(pod), .pix_out_ready(por), .irq(irq)
    );

    // output monitor: collect transfers, watch hold stability and input backpressure
    always @(negedge clk) begin
        if (hold_q && (!pov || pod !== hold_d)) stab_err++;
        if (pov && !por) stall_seen++;
        if (pov && !por && pir) rdy_err++;
        hold_q = pov & ~por;
        hold_d = pod;
        if (pov && por) outq.push_back(pod);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
        int n = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        do begin @(negedge clk); n++; end while (!ack && n < 20);
        if (!ack) chk("wb_ack_timeout", {31'b0, ack}, 32'd1);
        r = dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb(1'b1, a, d, s, r);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        wb(1'b0, a, 32'h0, 4'hF, r);
    endtask

    task automatic feed(input int npix, input int stall_at, output int used);
        int i = 0;
        used = 0;
        while (i < npix && used < 400) begin
            @(posedge clk); #1;
            por = !(used >= stall_at && used < stall_at + 5);
            piv = 1'b1; pid = pix[i];
            @(negedge clk);
            used++;
            if (pir) i++;
        end
        @(posedge clk); #1;
        piv = 1'b0; por = 1'b1;
        chk("feed_count", i, npix);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (pov && n < 50) begin @(negedge clk); n++; end
        chk("drain_timeout", {31'b0, pov}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_frame(input logic [31:0] ctrl, input logic [31:0] key, input logic [31:0] data, input int stall_at, input bit poke);
        logic [31:0] r, sd, lsb;
        logic [7:0]  e;
        int used, s0, st0, rd0;
        wr(KEY, key, 4'hF);
        wr(DATA, data, 4'hF);
        outq.delete();
        s0 = stall_seen; st0 = stab_err; rd0 = rdy_err;
        wr(CTRL, ctrl, 4'h1);
        fork
            feed(32, stall_at, used);
            if (poke) begin
                repeat (6) @(posedge clk);
                wr(CTRL, ctrl, 4'h1);
                wr(KEY, ~key, 4'hF);
            end
        join
        wait_idle();
        chk("out_count", outq.size(), 32);
        sd = data ^ key;
        for (int i = 0; i < 32; i++) begin
            lsb[i] = pix[i][0];
            e = ctrl[1] ? pix[i] : {pix[i][7:1], sd[i]};
            chk("out_pix", (i < outq.size()) ? {24'b0, outq[i]} : 32'hx, {24'b0, e});
        end
        if (stall_at < 1000) begin
            chk("stall_seen", {31'b0, (stall_seen - s0) >= 5}, 32'd1);
            chk("hold_stable", stab_err - st0, 0);
            chk("in_ready_low", rdy_err - rd0, 0);
        end else begin
            chk("throughput", used, 32);
        end
        rd(DATA, r);
        chk("data_after", r, ctrl[1] ? key ^ lsb : data);
        rd(STATUS, r);
        chk("status_done", {30'b0, r[1:0]}, 32'd2);
        if (poke) chk("ovr_set", {31'b0, r[2]}, 32'd1);
    endtask

    initial begin
        logic [31:0] r, k, d;
        logic [7:0]  first8;
        int used;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_in_ready", {31'b0, pir}, 0);
        chk("rst_out_valid", {31'b0, pov}, 0);
        chk("rst_out_data", {24'b0, pod}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        @(posedge clk); #1; rst = 1'b0;
        rd(STATUS, r); chk("rst_status", r, 0);
        rd(KEY, r);    chk("rst_key", r, 0);

        for (int i = 0; i < 32; i++) pix[i] = 8'h80;
        do_frame(32'h5, 32'hA5A5A5A5, 32'h0000FFFF, 1000, 1'b0);
        for (int i = 0; i < 8; i++) first8[i] = outq[i][0];
        chk("embed_lsb8", {24'b0, first8}, 32'h5A);
        chk("embed_out1", {24'b0, outq[1]}, 32'h81);
        rd(STATUS, r); chk("embed_status", r, 32'h2);
        @(negedge clk); chk("embed_irq", {31'b0, irq}, 1);
        rd(CTRL, r); chk("ctrl_read", r, 32'h4);

        for (int i = 0; i < 32; i++) pix[i] = outq[i];
        do_frame(32'h3, 32'hA5A5A5A5, 32'h0, 1000, 1'b0);
        rd(DATA, r); chk("extract_data", r, 32'h0000FFFF);
        @(negedge clk); chk("extract_irq_off", {31'b0, irq}, 0);

        for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
        do_frame(32'h5, $urandom, $urandom, 10, 1'b0);

        for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
        do_frame(32'h5, $urandom, $urandom, 1000, 1'b1);
        wr(STATUS, 32'h4, 4'h1);
        rd(STATUS, r); chk("ovr_cleared", r, 32'h2);

        wr(STATUS, 32'h2, 4'h1);
        @(negedge clk); chk("w1c_irq", {31'b0, irq}, 0);
        rd(STATUS, r); chk("w1c_status", r, 0);
        rd(B + 32'h14, r); chk("rsvd_read", r, 0);
        @(negedge clk); chk("ack_single", {31'b0, ack}, 0);
        wr(B + 32'h18, 32'hFFFFFFFF, 4'hF);
        rd(B + 32'h18, r); chk("rsvd_write", r, 0);

        wr(KEY, 32'h0, 4'hF);
        wr(KEY, 32'h11223344, 4'b0101);
        rd(KEY, r); chk("key_lanes", r, 32'h00220044);
        wr(DATA, 32'hFFFFFFFF, 4'hF);
        wr(DATA, 32'h0, 4'b1000);
        rd(DATA, r); chk("data_lanes", r, 32'h00FFFFFF);

        for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
        wr(KEY, 32'hCAFEF00D, 4'hF);
        wr(CTRL, 32'h5, 4'h1);
        feed(10, 1000, used);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, pov}, 0);
        chk("abort_in_ready", {31'b0, pir}, 0);
        chk("abort_irq", {31'b0, irq}, 0);
        rd(STATUS, r); chk("abort_status", r, 0);
        rd(KEY, r);    chk("abort_key", r, 0);
        rd(DATA, r);   chk("abort_data", r, 0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 32; i++) pix[i] = 8'($urandom);
            k = $urandom; d = $urandom;
            do_frame({29'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1}, k, d, (f == 2) ? 7 : 1000, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
